// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The loader FSM walks IDLE -> HDR -> DATA -> CSUM and then returns to IDLE.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a big-endian byte stream into words. word_valid flags the byte that completes a word.
// When word_valid is high, word already contains that final byte.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-BYTE_W-1:0] shift_q;
  logic [1:0]               cnt_q;

  // The word is combinational so the loader can register it on the same edge
  // that accepts the final byte.
  assign word       = {shift_q, byte_data};
  assign word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= word[WORD_W-BYTE_W-1:0];
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed program image from a byte stream into the instruction memory.
// The CPU stays held until a load completes with a correct checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  state_t              state_q, state_d;
  logic [7:0]          last_idx_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [CSUM_W-1:0]   sum_q;
  logic [CSUM_W-1:0]   sum_next;
  logic [WORD_W-1:0]   packed_word;
  logic                word_valid;
  logic                accept;
  logic                start_load;
  logic                last_word;

  assign in_ready   = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = in_valid && in_ready;
  assign start_load = (state_q == IDLE) && start;
  assign sum_next   = sum_q + in_data;
  assign last_word  = word_valid && (word_idx_q == ADDR_W'(last_idx_q));

  imem_word_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_load),
    .byte_valid (accept && (state_q == DATA)),
    .byte_data  (in_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  // NOTE: next state gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)     state_d = HDR;
      HDR:  if (accept)    state_d = DATA;
      DATA: if (last_word) state_d = CSUM;
      CSUM: if (accept)    state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters, checksum and the memory write port. start_load and accept are
  // mutually exclusive because in_ready is low in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx_q <= '0;
      word_idx_q <= '0;
      sum_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (start_load) begin
        err        <= 1'b0;
        cpu_hold   <= 1'b1;
        sum_q      <= '0;
        word_idx_q <= '0;
        last_idx_q <= '0;
      end
      if (accept) begin
        unique case (state_q)
          HDR: begin
            last_idx_q <= in_data;
            sum_q      <= sum_next;
          end
          DATA: begin
            sum_q <= sum_next;
            if (word_valid) begin
              mem_we     <= 1'b1;
              mem_addr   <= word_idx_q;
              mem_wdata  <= packed_word;
              word_idx_q <= word_idx_q + ADDR_W'(1);
            end
          end
          CSUM: begin
            done <= 1'b1;
            // A failed image keeps the CPU stalled; a good one releases it.
            if (sum_next != '0) err      <= 1'b1;
            else                cpu_hold <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory bank before the single-cycle CPU runs. It accepts a byte stream (header, big-endian instruction words, checksum) over a valid/ready handshake, packs bytes into 32-bit words, and drives the instruction memory write port one word per write pulse. It holds the CPU stalled while loading and releases it only after a load passes its checksum.

## Interface
- `ADDR_W`, 8: word address width; memory depth is 2^ADDR_W words.
- `WORD_W`, 32: instruction width. Must be 4 × 8.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request to begin a load. Honoured only in IDLE.
- `in_valid` in 1: `in_data` holds a byte.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: instruction memory write strobe, one cycle per word.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_wdata` out WORD_W: instruction word to write.
- `busy` out 1: high in HDR, DATA and CSUM.
- `done` out 1: one-cycle pulse when a load finishes, whether it passes or fails.
- `err` out 1: checksum failure flag. Sticky; cleared by the next accepted `start`.
- `cpu_hold` out 1: stall to the CPU.

## Operation
- **Reset values:** every output is 0. The state is IDLE and all counters are 0.
- **Byte acceptance:** a byte is accepted on a rising edge where `in_valid && in_ready`.
- **`in_ready`:** decoded from the registered state only; high in HDR, DATA and CSUM.
- **IDLE:**
  - `start` → HDR.
  - On the same edge: clear `err`, set `cpu_hold`, clear the sum, the byte counter and the word counter.
- **HDR:**
  - The accepted byte is C; the load carries C+1 words (1..256).
  - Store C, add it to the sum, go to DATA.
- **DATA:**
  - Bytes arrive MSB first into a shift register, and each is added to the sum.
  - On the 4th byte of a word, register `mem_wdata` ← assembled word and `mem_addr` ← word index.
  - Assert `mem_we` on the next cycle.
  - The word index then increments. It is ADDR_W bits and may wrap from 255 to 0 after the final write; the wrapped value is never used.
  - After byte 4 of word index C → CSUM.
- **CSUM:**
  - Accept one byte, K. The load passes iff (sum + K) mod 256 == 0.
  - Go to IDLE and pulse `done` on the next cycle.
  - On pass: drop `cpu_hold`.
  - On fail: set `err` and keep `cpu_hold` high, so the CPU never runs a corrupt image.
- **Sum:** 8-bit, wraps modulo 256.
- **`start` while busy:** ignored, with no effect on the counters.
- **Writes on failure:** words already written stay in memory. No rollback.
- **Reset mid-load:** asynchronous return to reset values; a partially written image is left in memory. The next load restarts at address 0.

## Timing
- Full throughput: one byte per cycle with `in_valid` held high.
- `in_ready` never drops between bytes of one load.
- `mem_we` is high exactly 1 cycle after the edge accepting each word's 4th byte. `mem_addr` and `mem_wdata` are stable during that cycle.
- `mem_we` for the last word coincides with the first CSUM cycle.
- `done`, and `err` on failure, become visible 1 cycle after the checksum byte is accepted. `cpu_hold` falls in that same cycle on pass.
- `busy` is 0 in the `done` cycle.
- Minimum load length is 4C+6 accepted bytes. `done` follows 1 cycle after the last of them.
- Gaps in `in_valid` stall the FSM with no other effect.

## Structure
- `imem_loader_pkg`:
  - state enum: IDLE, HDR, DATA, CSUM;
  - `BYTES_PER_WORD = 4`;
  - `CSUM_W = 8`.
- Sub-module `imem_word_packer`:
  - byte shift register and 2-bit byte counter;
  - `word_valid` pulse when the 4th byte arrives.
- The FSM, the sum and the write port live in `imem_loader`.
- Scope: roughly 150–250 lines of RTL.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle → all outputs 0 immediately, without waiting for a clock edge; `in_ready`=0.
- **Single word:** `start`, then bytes 00 8C 01 00 01 72 →
  - one `mem_we` with addr 0, data 0x8C010001;
  - `done` pulse; `err`=0;
  - `cpu_hold` high during the load, 0 after `done`.
- **Bad checksum:** same stream with last byte 73 →
  - write still occurs; `done` pulses; `err`=1; `cpu_hold` stays 1;
  - a new `start` clears `err`.
- **Backpressure and gaps:** 3-word load with `in_valid` randomly deasserted →
  - writes at addr 0,1,2 with the correct words, in order;
  - no extra `mem_we`;
  - `done` only after the checksum byte.
- **Full depth:** C=FF, word i = 0x00000100 + i, correct checksum →
  - exactly 256 writes, addr 0..255, no duplicate at addr 0;
  - `done` pulses; `err`=0.
- **Mid-load events:**
  - `start` pulsed during DATA → ignored;
  - `rst_n` low after 2 words → outputs reset;
  - the subsequent single-word load writes addr 0 and passes.
